// File: rtl/frost32_mem_access_unit.sv
// Frost32 data-memory bridge: byte-lane steering, alignment check, read
// extraction and a bounded-wait request/ack handshake to a word-wide SRAM.
module frost32_mem_access_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_mem_access,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_data_out,
  input  logic                  cpu_access_type,
  input  logic [1:0]            cpu_access_size,
  output logic [31:0]           cpu_data_in,
  output logic                  cpu_busy,
  output logic                  cpu_done,
  output logic                  cpu_err,
  output logic                  sram_req,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-3:0] sram_addr,
  output logic [3:0]            sram_be,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata,
  input  logic                  sram_ack
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SZ_32 = 2'd0;
  localparam logic [1:0] SZ_16 = 2'd1;
  localparam logic [1:0] SZ_8  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       off_q;
  logic [1:0]       size_q;

  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        bad_c;
  logic [31:0] rdata_fmt_c;

  // Lane steering and alignment check on the incoming CPU request
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = cpu_data_out;
    bad_c   = 1'b0;
    case (cpu_access_size)
      SZ_8: begin
        be_c    = 4'b0001 << cpu_addr[1:0];
        wdata_c = {4{cpu_data_out[7:0]}};
      end
      SZ_16: begin
        be_c    = cpu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{cpu_data_out[15:0]}};
        bad_c   = cpu_addr[0];
      end
      SZ_32: begin
        bad_c = (cpu_addr[1:0] != 2'b00);
      end
      default: begin
        bad_c = 1'b1;
      end
    endcase
  end

  // Right-justify and zero-extend the addressed lanes of the SRAM word
  always_comb begin
    rdata_fmt_c = sram_rdata;
    case (size_q)
      SZ_8:    rdata_fmt_c = {24'b0, sram_rdata[{off_q, 3'b000} +: 8]};
      SZ_16:   rdata_fmt_c = {16'b0, off_q[1] ? sram_rdata[31:16] : sram_rdata[15:0]};
      default: rdata_fmt_c = sram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      off_q       <= '0;
      size_q      <= '0;
      cpu_data_in <= '0;
      cpu_busy    <= 1'b0;
      cpu_done    <= 1'b0;
      cpu_err     <= 1'b0;
      sram_req    <= 1'b0;
      sram_we     <= 1'b0;
      sram_addr   <= '0;
      sram_be     <= '0;
      sram_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_mem_access) begin
            off_q    <= cpu_addr[1:0];
            size_q   <= cpu_access_size;
            cpu_busy <= 1'b1;
            if (bad_c) begin
              state    <= RESP;
              cpu_done <= 1'b1;
              cpu_err  <= 1'b1;
            end else begin
              state      <= ACCESS;
              wait_cnt   <= '0;
              sram_req   <= 1'b1;
              sram_we    <= cpu_access_type;
              sram_addr  <= cpu_addr[ADDR_WIDTH-1:2];
              sram_be    <= be_c;
              sram_wdata <= wdata_c;
            end
          end
        end
        ACCESS: begin
          // Ack takes priority over an expiring wait counter
          if (sram_ack) begin
            if (!sram_we) begin
              cpu_data_in <= rdata_fmt_c;
            end
            sram_req <= 1'b0;
            state    <= RESP;
            cpu_done <= 1'b1;
            cpu_err  <= 1'b0;
          end else if (wait_cnt == CNT_LAST) begin
            sram_req <= 1'b0;
            state    <= RESP;
            cpu_done <= 1'b1;
            cpu_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state    <= IDLE;
          cpu_busy <= 1'b0;
          cpu_done <= 1'b0;
          cpu_err  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frost32_mem_access_unit.sv
// Bench for frost32_mem_access_unit: directed test-plan scenarios plus
// randomized accesses checked against a byte-lane reference model.
module tb_frost32_mem_access_unit;

  localparam int unsigned AW    = 32;
  localparam int unsigned TO    = 16;
  localparam int          NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_data_out = '0;
  logic          cpu_access_type = 1'b0;
  logic [1:0]    cpu_access_size = '0;
  logic [31:0]   cpu_data_in;
  logic          cpu_busy, cpu_done, cpu_err;
  logic          sram_req, sram_we;
  logic [AW-3:0] sram_addr;
  logic [3:0]    sram_be;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;
  logic          sram_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_rd = '0;

  typedef struct {
    int          req_cycles;
    int          req_rises;
    int          done_cycle;
    int          done_count;
    bit          err;
    logic [31:0] din;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          we;
    logic [AW-3:0] saddr;
    bit          stable;
  } obs_t;

  typedef struct {
    bit          bad;
    int          req_cycles;
    int          done_cycle;
    bit          err;
    logic [31:0] din;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  frost32_mem_access_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_mem_access(cpu_req), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_access_type(cpu_access_type), .cpu_access_size(cpu_access_size),
    .cpu_data_in(cpu_data_in), .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_be(sram_be),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack)
  );

  always #5 clk = ~clk;

  // Reference: an n-byte access covers lanes base..base+n-1, base = addr rounded down to n
  function automatic void model(input logic [AW-1:0] addr, input logic [31:0] data,
                                input bit we, input logic [1:0] size, input int delay,
                                input logic [31:0] rdata, output exp_t e);
    int n, a, base;
    logic [31:0] ext;
    n = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : (size == 2'd2) ? 1 : 0;
    a = int'(addr[1:0]);
    e.bad = (n == 0) || ((a % n) != 0);
    base = (n == 0) ? 0 : (a / n) * n;
    e.be = '0;
    e.wdata = '0;
    for (int i = 0; i < 4; i++) begin
      e.be[i] = (n != 0) && (i >= base) && (i < base + n);
      if (n != 0) e.wdata[8*i +: 8] = data[8*(i % n) +: 8];
    end
    ext = rdata >> (8 * base);
    if (n == 1) ext = ext & 32'h0000_00FF;
    if (n == 2) ext = ext & 32'h0000_FFFF;
    if (e.bad) begin
      e.req_cycles = 0; e.done_cycle = 1; e.err = 1'b1;
    end else if (delay < int'(TO)) begin
      e.req_cycles = delay + 1; e.done_cycle = delay + 2; e.err = 1'b0;
      if (!we) model_rd = ext;
    end else begin
      e.req_cycles = int'(TO); e.done_cycle = int'(TO) + 1; e.err = 1'b1;
    end
    e.din = model_rd;
  endfunction

  // Issue one request and record what the DUT does; cycle k = k-th cycle after the request edge
  task automatic run_access(input logic [AW-1:0] addr, input logic [31:0] data, input bit we,
                            input logic [1:0] size, input int delay, input logic [31:0] rdata,
                            input bit hold, output obs_t o);
    bit first = 1'b1;
    bit prev_req = 1'b0;
    o.req_cycles = 0; o.req_rises = 0; o.done_cycle = 0; o.done_count = 0;
    o.err = 1'b0; o.din = '0; o.be = '0; o.wdata = '0; o.we = 1'b0; o.saddr = '0;
    o.stable = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = addr; cpu_data_out = data;
    cpu_access_type = we; cpu_access_size = size;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!hold) cpu_req = 1'b0;
      if (sram_req) begin
        o.req_cycles++;
        if (first) begin
          o.be = sram_be; o.wdata = sram_wdata; o.we = sram_we; o.saddr = sram_addr;
          first = 1'b0;
        end else if (sram_be !== o.be || sram_wdata !== o.wdata || sram_we !== o.we ||
                     sram_addr !== o.saddr) begin
          o.stable = 1'b0;
        end
      end
      if (sram_req && !prev_req) o.req_rises++;
      prev_req = sram_req;
      if (cpu_done === 1'b1) begin
        if (o.done_count == 0) begin
          o.done_cycle = k; o.err = cpu_err; o.din = cpu_data_in;
        end
        o.done_count++;
        cpu_req = 1'b0;
      end
      sram_ack   = (k == delay + 1);
      sram_rdata = (k == delay + 1) ? rdata : $urandom();
      if (o.done_count != 0 && k >= o.done_cycle + 3) break;
    end
    sram_ack = 1'b0;
    cpu_req  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({cpu_data_in, cpu_busy, cpu_done, cpu_err, sram_req, sram_we, sram_addr, sram_be,
         sram_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got din=%h busy=%b done=%b req=%b be=%b wdata=%h want all zero",
               cpu_data_in, cpu_busy, cpu_done, sram_req, sram_be, sram_wdata);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_write();
    obs_t o;
    run_access(32'h100, 32'hDEADBEEF, 1'b1, 2'd0, 0, 32'h0, 1'b0, o);
    n_cmp++; if (o.saddr !== 30'h40) begin n_err++; $display("FAIL word_wr_addr got %h want 40", o.saddr); end
    n_cmp++; if (o.be !== 4'b1111) begin n_err++; $display("FAIL word_wr_be got %b want 1111", o.be); end
    n_cmp++; if (o.wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL word_wr_wdata got %h want deadbeef", o.wdata); end
    n_cmp++; if (o.we !== 1'b1) begin n_err++; $display("FAIL word_wr_we got %b want 1", o.we); end
    n_cmp++; if (o.done_cycle != 2 || o.err !== 1'b0) begin n_err++; $display("FAIL word_wr_done got cycle=%0d err=%b want cycle=2 err=0", o.done_cycle, o.err); end
    n_cmp++; if (o.din !== model_rd) begin n_err++; $display("FAIL word_wr_din got %h want %h", o.din, model_rd); end
  endtask

  task automatic test_byte_read();
    obs_t o;
    run_access(32'h103, 32'h0, 1'b0, 2'd2, 3, 32'hA1B2C3D4, 1'b0, o);
    model_rd = 32'h0000_00A1;
    n_cmp++; if (o.be !== 4'b1000 || o.we !== 1'b0) begin n_err++; $display("FAIL byte_rd_be got be=%b we=%b want be=1000 we=0", o.be, o.we); end
    n_cmp++; if (o.din !== 32'h0000_00A1) begin n_err++; $display("FAIL byte_rd_data got %h want 000000a1", o.din); end
    n_cmp++; if (o.done_cycle != 5 || o.err !== 1'b0) begin n_err++; $display("FAIL byte_rd_done got cycle=%0d err=%b want cycle=5 err=0", o.done_cycle, o.err); end
    n_cmp++; if (o.req_cycles != 4 || !o.stable) begin n_err++; $display("FAIL byte_rd_req got cycles=%0d stable=%b want 4 stable=1", o.req_cycles, o.stable); end
  endtask

  task automatic test_halfword();
    obs_t o;
    run_access(32'h202, 32'h1234ABCD, 1'b1, 2'd1, 1, 32'h0, 1'b0, o);
    n_cmp++; if (o.be !== 4'b1100) begin n_err++; $display("FAIL half_wr_be got %b want 1100", o.be); end
    n_cmp++; if (o.wdata !== 32'hABCDABCD) begin n_err++; $display("FAIL half_wr_wdata got %h want abcdabcd", o.wdata); end
    n_cmp++; if (o.din !== model_rd) begin n_err++; $display("FAIL half_wr_din got %h want %h", o.din, model_rd); end
    run_access(32'h202, 32'h0, 1'b0, 2'd1, 1, 32'h5566_7788, 1'b0, o);
    model_rd = 32'h0000_5566;
    n_cmp++; if (o.din !== 32'h0000_5566 || o.done_cycle != 3) begin n_err++; $display("FAIL half_rd got din=%h cycle=%0d want 00005566 cycle=3", o.din, o.done_cycle); end
  endtask

  task automatic test_bad_requests();
    obs_t o;
    logic [AW-1:0] addrs [3] = '{32'h101, 32'h103, 32'h200};
    logic [1:0]    sizes [3] = '{2'd0, 2'd1, 2'd3};
    for (int i = 0; i < 3; i++) begin
      run_access(addrs[i], $urandom(), 1'($urandom_range(0, 1)), sizes[i], 0, $urandom(), 1'b0, o);
      n_cmp++;
      if (o.done_cycle != 1 || o.err !== 1'b1 || o.req_rises != 0 || o.done_count != 1 ||
          o.din !== model_rd) begin
        n_err++;
        $display("FAIL bad_req%0d got cycle=%0d err=%b req_rises=%0d dones=%0d din=%h want 1/1/0/1/%h",
                 i, o.done_cycle, o.err, o.req_rises, o.done_count, o.din, model_rd);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    logic [31:0] rd;
    bit stray = 1'b0;
    run_access(32'h40, 32'h0, 1'b0, 2'd0, NEVER, 32'h0, 1'b0, o);
    n_cmp++; if (o.req_cycles != int'(TO) || o.req_rises != 1) begin n_err++; $display("FAIL timeout_req got cycles=%0d rises=%0d want %0d/1", o.req_cycles, o.req_rises, TO); end
    n_cmp++; if (o.done_cycle != int'(TO) + 1 || o.err !== 1'b1) begin n_err++; $display("FAIL timeout_done got cycle=%0d err=%b want %0d err=1", o.done_cycle, o.err, TO + 1); end
    n_cmp++; if (o.din !== model_rd) begin n_err++; $display("FAIL timeout_din got %h want %h", o.din, model_rd); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cpu_busy || cpu_done || sram_req) stray = 1'b1;
      sram_ack = 1'b1; sram_rdata = $urandom();
    end
    @(negedge clk);
    if (cpu_busy || cpu_done || sram_req || cpu_data_in !== model_rd) stray = 1'b1;
    sram_ack = 1'b0;
    n_cmp++; if (stray) begin n_err++; $display("FAIL late_ack got activity/data change want idle din=%h", model_rd); end
    rd = $urandom();
    run_access(32'h44, 32'h0, 1'b0, 2'd0, 2, rd, 1'b0, o);
    model_rd = rd;
    n_cmp++; if (o.din !== rd || o.err !== 1'b0 || o.done_cycle != 4) begin n_err++; $display("FAIL post_timeout_rd got din=%h err=%b cycle=%0d want %h/0/4", o.din, o.err, o.done_cycle, rd); end
  endtask

  task automatic test_ack_at_timeout();
    obs_t o;
    logic [31:0] rd;
    rd = $urandom();
    run_access(32'h48, 32'h0, 1'b0, 2'd0, int'(TO) - 1, rd, 1'b0, o);
    model_rd = rd;
    n_cmp++;
    if (o.err !== 1'b0 || o.done_cycle != int'(TO) + 1 || o.req_cycles != int'(TO) || o.din !== rd) begin
      n_err++;
      $display("FAIL ack_at_timeout got err=%b cycle=%0d req=%0d din=%h want 0/%0d/%0d/%h",
               o.err, o.done_cycle, o.req_cycles, o.din, TO + 1, TO, rd);
    end
  endtask

  task automatic test_held_request();
    obs_t o;
    run_access(32'h80, $urandom(), 1'b1, 2'd0, 1, 32'h0, 1'b1, o);
    n_cmp++;
    if (o.req_rises != 1 || o.done_count != 1 || o.done_cycle != 3) begin
      n_err++;
      $display("FAIL held_req got rises=%0d dones=%0d cycle=%0d want 1/1/3", o.req_rises, o.done_count, o.done_cycle);
    end
  endtask

  task automatic test_reset_mid_access();
    bit stray = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h84; cpu_access_type = 1'b0; cpu_access_size = 2'd0;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (sram_req !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre got req=%b want 1", sram_req); end
    rst_n = 1'b0;
    #1;
    model_rd = '0;
    n_cmp++;
    if ({cpu_data_in, cpu_busy, cpu_done, cpu_err, sram_req, sram_we, sram_addr, sram_be,
         sram_wdata} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs got din=%h busy=%b req=%b addr=%h be=%b want all zero",
               cpu_data_in, cpu_busy, sram_req, sram_addr, sram_be);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sram_ack = 1'b1;
      @(negedge clk);
      if (cpu_done || cpu_busy || sram_req) stray = 1'b1;
    end
    sram_ack = 1'b0;
    n_cmp++; if (stray) begin n_err++; $display("FAIL rst_mid_after got activity after reset want idle"); end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [AW-1:0] addr;
    logic [31:0] data, rd;
    logic [1:0] size;
    bit we;
    int delay;
    for (int i = 0; i < 40; i++) begin
      addr  = $urandom();
      data  = $urandom();
      rd    = $urandom();
      size  = 2'($urandom_range(0, 3));
      we    = 1'($urandom_range(0, 1));
      delay = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 2)) : int'($urandom_range(0, 4));
      model(addr, data, we, size, delay, rd, e);
      run_access(addr, data, we, size, delay, rd, 1'b0, o);
      n_cmp++;
      if (o.done_cycle != e.done_cycle || o.err !== e.err || o.req_cycles != e.req_cycles ||
          o.done_count != 1 || o.din !== e.din) begin
        n_err++;
        $display("FAIL rand%0d_resp a=%h sz=%0d we=%b d=%0d got cyc=%0d err=%b req=%0d dn=%0d din=%h want %0d/%b/%0d/1/%h",
                 i, addr, size, we, delay, o.done_cycle, o.err, o.req_cycles, o.done_count, o.din,
                 e.done_cycle, e.err, e.req_cycles, e.din);
      end
      if (!e.bad) begin
        n_cmp++;
        if (o.be !== e.be || o.wdata !== e.wdata || o.we !== we || o.saddr !== addr[AW-1:2] ||
            !o.stable || o.req_rises != 1) begin
          n_err++;
          $display("FAIL rand%0d_bus got be=%b wd=%h we=%b sa=%h st=%b rises=%0d want be=%b wd=%h we=%b sa=%h",
                   i, o.be, o.wdata, o.we, o.saddr, o.stable, o.req_rises, e.be, e.wdata, we, addr[AW-1:2]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_read();
    test_halfword();
    test_bad_requests();
    test_timeout();
    test_ack_at_timeout();
    test_held_request();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frost32_mem_access_unit.md
# frost32_mem_access_unit

Bridges the Frost32 CPU data-memory port to a word-wide, handshaked synchronous SRAM. Sits directly downstream of the CPU's memory-request outputs (data, addr, access type, access size, req_mem_access) and produces the CPU's returned read data. It performs byte-lane steering, alignment checking, read-data extraction and a bounded-wait handshake with the memory.

## Interface
- `ADDR_WIDTH`, default 32: width of the CPU byte address.
- `TIMEOUT_CYCLES`, default 16: maximum number of cycles `sram_req` is held without `sram_ack` before the access is aborted. Minimum value is 1.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cpu_req_mem_access`, input, 1: CPU request strobe. Sampled only in IDLE.
- `cpu_addr`, input, ADDR_WIDTH: byte address.
- `cpu_data_out`, input, 32: write data, right-justified.
- `cpu_access_type`, input, 1: 0 = read (DiatRead), 1 = write (DiatWrite).
- `cpu_access_size`, input, 2: 0 = 32-bit, 1 = 16-bit, 2 = 8-bit, 3 = bad.
- `cpu_data_in`, output, 32: read result, zero-extended, right-justified.
- `cpu_busy`, output, 1: high whenever state ≠ IDLE.
- `cpu_done`, output, 1: one-cycle completion pulse.
- `cpu_err`, output, 1: error flag, qualified by `cpu_done`.
- `sram_req`, output, 1: memory request, held until ack or timeout.
- `sram_we`, output, 1: write enable.
- `sram_addr`, output, ADDR_WIDTH-2: word address, equal to `cpu_addr[ADDR_WIDTH-1:2]`.
- `sram_be`, output, 4: byte enables. Bit i selects byte lane [8i+7:8i].
- `sram_wdata`, output, 32: lane-replicated write data.
- `sram_rdata`, input, 32: read data, valid in the cycle `sram_ack` is high.
- `sram_ack`, input, 1: memory completion.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE, on `cpu_req_mem_access`=1:
  - Latch addr, data, type and size.
  - Error case: size = 3, or 16-bit with `addr[0]`=1, or 32-bit with `addr[1:0]`≠0. Go to RESP with err=1. No SRAM request is issued.
  - Otherwise: go to ACCESS and clear the wait counter.
- ACCESS:
  - `sram_req`=1. `sram_addr`, `sram_we`, `sram_be` and `sram_wdata` are registered and stable for the whole state.
  - On `sram_ack`: for reads, capture the formatted read data into `cpu_data_in`. Go to RESP with err=0.
  - Otherwise, if counter = TIMEOUT_CYCLES-1: go to RESP with err=1. `cpu_data_in` is unchanged.
  - Otherwise: increment the counter.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP: `cpu_done`=1 and `cpu_err` is valid. Next state is IDLE.
- Write lane steering, where a = addr[1:0]:
  - 8-bit: `be` = 1<<a, `wdata` = {4{d[7:0]}}.
  - 16-bit: `be` = a[1] ? 4'b1100 : 4'b0011, `wdata` = {2{d[15:0]}}.
  - 32-bit: `be` = 4'b1111, `wdata` = d.
- Reads use the same `be` values with `sram_we`=0.
- Read extraction:
  - 8-bit: `cpu_data_in` = {24'b0, byte lane a}.
  - 16-bit: `cpu_data_in` = {16'b0, a[1] ? rdata[31:16] : rdata[15:0]}.
  - 32-bit: `cpu_data_in` = rdata.
- Writes leave `cpu_data_in` unchanged.
- `cpu_req_mem_access` while busy is ignored; the CPU must wait for `cpu_done`.
- `sram_ack` outside ACCESS is ignored. This includes a late ack arriving after a timeout.

## Timing
- Reset values of all outputs are 0: `cpu_data_in`, `cpu_busy`, `cpu_done`, `cpu_err`, `sram_req`, `sram_we`, `sram_addr`, `sram_be`, `sram_wdata`.
- Reset asserted mid-access drops `sram_req` immediately (asynchronously). No `cpu_done` is produced.
- Valid access, request sampled at edge E0:
  - `sram_req` is high from E0 onward.
  - Ack in the first ACCESS cycle gives `cpu_done` in the cycle after edge E1.
  - Each cycle of ack delay adds one cycle of latency.
- Error access: `cpu_done` with `cpu_err` is high in the cycle after E0. `sram_req` never rises.
- Timeout: `sram_req` is high for exactly TIMEOUT_CYCLES cycles. `cpu_done` with `cpu_err` follows in the next cycle.
- Throughput: a new request can be sampled in the IDLE cycle immediately after RESP, i.e. at most one access every 3 cycles.
- `cpu_data_in` is valid from the `cpu_done` cycle and holds until the next successful read.

## Test plan
- Word write, addr=0x100, data=0xDEADBEEF, ack immediate -> `sram_addr`=0x40, `be`=1111, `wdata`=0xDEADBEEF, `we`=1; `cpu_done` in 2nd cycle after the request edge with `err`=0.
- Byte read, addr=0x103, rdata=0xA1B2C3D4, ack after 3 wait cycles -> `be`=1000, `cpu_data_in`=0x000000A1, `cpu_done` 5 cycles after the request edge.
- Halfword write, addr=0x202, data=0x1234ABCD -> `be`=1100, `wdata`=0xABCDABCD; halfword read at 0x202 with rdata=0x5566_7788 -> `cpu_data_in`=0x00005566.
- Misaligned/bad requests: 32-bit at 0x101, 16-bit at 0x103, and size=3 -> each gives `cpu_done`+`cpu_err` one cycle after the request edge, `sram_req` never asserted, `cpu_data_in` unchanged.
- Timeout with TIMEOUT_CYCLES=16 and ack never asserted -> `sram_req` high exactly 16 cycles, then `cpu_done`+`cpu_err`. A late ack in IDLE is ignored, and the following normal read completes correctly.
- Boundary and reset cases:
  - Ack in the exact timeout cycle -> success, `err`=0.
  - `cpu_req_mem_access` held high during busy -> only one access is issued.
  - `rst_n` pulsed low during ACCESS -> all outputs 0 at once, no `cpu_done`, FSM in IDLE.
